// File: rtl/prog_loader.sv
// prog_loader: receives a program over a byte-wide 4-phase host handshake and writes 16-bit words
// into instruction memory while holding the CPU in reset. Optional build macro: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_req,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_stb,
  output logic              o_byte_ack,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t r_state, w_nextState;

  logic [SYNC_STAGES-1:0] r_reqSync, r_stbSync;
  logic                   r_reqPrev, r_stbPrev;
  logic                   w_req, w_stb, w_reqRise, w_accept;
  logic                   w_active, w_abort, w_lastWord;
  logic                   r_byteAck, r_loadDone, r_loadErr;
  logic [7:0]             r_hi;
  logic [8:0]             r_len, r_wordCnt;
  logic [ADDR_W-1:0]      r_memAddr;
  logic [DATA_W-1:0]      r_memWdata;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]             r_xor;
`endif

  // Host signals are asynchronous; all edge detection uses the synchronized copies.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reqSync <= '0;
      r_stbSync <= '0;
      r_reqPrev <= 1'b0;
      r_stbPrev <= 1'b0;
    end else begin
      r_reqSync <= {r_reqSync[SYNC_STAGES-2:0], i_load_req};
      r_stbSync <= {r_stbSync[SYNC_STAGES-2:0], i_byte_stb};
      r_reqPrev <= w_req;
      r_stbPrev <= w_stb;
    end
  end

  assign w_req      = r_reqSync[SYNC_STAGES-1];
  assign w_stb      = r_stbSync[SYNC_STAGES-1];
  assign w_reqRise  = w_req & ~r_reqPrev;
  assign w_accept   = w_stb & ~r_stbPrev & ~r_byteAck;
  assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_abort    = w_active & ~w_req;
  assign w_lastWord = (r_wordCnt + 9'd1) == r_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_reqRise) w_nextState = S_LEN;
      S_LEN:  if (w_accept)  w_nextState = S_HI;
      S_HI:   if (w_accept)  w_nextState = S_LO;
      S_LO:   if (w_accept)  w_nextState = S_WR;
      S_WR: begin
        if (w_lastWord) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          w_nextState = S_CHK;
`else
          w_nextState = S_DONE;
`endif
        end else begin
          w_nextState = S_HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:  if (w_accept)  w_nextState = S_DONE;
`endif
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    // A write already in WR still pulses this cycle; only the next state is overridden.
    if (w_abort) w_nextState = S_IDLE;
  end

  always_comb begin
    o_mem_we    = (r_state == S_WR);
    o_cpu_hold  = w_active;
    o_byte_ack  = r_byteAck;
    o_mem_addr  = r_memAddr;
    o_mem_wdata = r_memWdata;
    o_load_done = r_loadDone;
    o_load_err  = r_loadErr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byteAck  <= 1'b0;
      r_loadDone <= 1'b0;
      r_loadErr  <= 1'b0;
      r_hi       <= '0;
      r_len      <= '0;
      r_wordCnt  <= '0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else begin
      if (w_accept)    r_byteAck <= 1'b1;
      else if (!w_stb) r_byteAck <= 1'b0;

      if (r_state == S_IDLE && w_reqRise) begin
        r_loadDone <= 1'b0;
        r_loadErr  <= 1'b0;
        r_memAddr  <= '0;
        r_wordCnt  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        r_xor      <= '0;
`endif
      end

      // Bytes accepted in IDLE, WR or DONE are acknowledged but dropped.
      if (w_accept) begin
        case (r_state)
          S_LEN: r_len      <= (i_byte_in == 8'd0) ? 9'd256 : {1'b0, i_byte_in};
          S_HI:  r_hi       <= i_byte_in;
          S_LO:  r_memWdata <= {r_hi, i_byte_in};
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CHK: if (i_byte_in != r_xor) r_loadErr <= 1'b1;
`endif
          default: ;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        if (r_state == S_LEN || r_state == S_HI || r_state == S_LO)
          r_xor <= r_xor ^ i_byte_in;
`endif
      end

      if (r_state == S_WR) begin
        r_memAddr <= r_memAddr + ADDR_W'(1);
        r_wordCnt <= r_wordCnt + 9'd1;
      end

      if (w_abort) r_loadErr <= 1'b1;
      if (w_nextState == S_DONE && r_state != S_DONE) r_loadDone <= 1'b1;
    end
  end

endmodule
